// File: rtl/autocorr_tempo_est.sv
// autocorr_tempo_est: tempo estimator that autocorrelates a spectral-flux history and folds the best lag into a BPM range
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous active-low reset
//   flux_valid   qualifies flux_in for one cycle
//   flux_in      spectral-flux sample (W bits, unsigned)
//   BPM_estimate current tempo estimate in integer BPM
//   bpm_valid    one-cycle pulse when BPM_estimate has been refreshed
//   state_out    FSM state (IDLE=0, CORR=1, DIV=2, FOLD=3, DONE=4)
//   drop_count   saturating count of samples that arrived while busy
module autocorr_tempo_est #(
  parameter int W            = 16,
  parameter int N            = 256,
  parameter int WIN          = 128,
  parameter int LAG_MIN      = 20,
  parameter int LAG_MAX      = 100,
  parameter int HOP          = 64,
  parameter int FLUX_RATE_HZ = 86,
  parameter int MIN_BPM      = 60,
  parameter int MAX_BPM      = 180,
  parameter int SMOOTH_SH    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flux_valid,
  input  logic [W-1:0] flux_in,
  output logic [15:0]  BPM_estimate,
  output logic         bpm_valid,
  output logic [2:0]   state_out,
  output logic [7:0]   drop_count
);
  localparam int PW  = $clog2(N);
  localparam int FW  = $clog2(N + 1);
  localparam int HW  = $clog2(HOP + 1);
  localparam int JW  = $clog2(WIN + 1);
  localparam int LW  = $clog2(LAG_MAX + 1);
  localparam int PRW = 2 * W;
  localparam int AW  = 2 * W + $clog2(WIN);
  localparam int K   = 60 * FLUX_RATE_HZ;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CORR = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FOLD = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  logic [W-1:0]  r_buf [N];
  logic [2:0]    r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_base;
  logic [FW-1:0] r_fill;
  logic [HW-1:0] r_hop;
  logic [JW-1:0] r_j;
  logic [LW-1:0] r_lag;
  logic [LW-1:0] r_best_lag;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_best;
  logic [15:0]   r_quo;
  logic [15:0]   r_rem;
  logic [3:0]    r_cnt;
  logic [3:0]    r_steps;
  logic [15:0]   r_bpm;
  logic          r_valid;
  logic [7:0]    r_drops;
  logic          r_first;
  logic                w_wr;
  logic                w_drop;
  logic                w_go;
  logic [PW-1:0]       w_ia;
  logic [PW-1:0]       w_ib;
  logic [PRW-1:0]      w_prod;
  logic                w_gt;
  logic [AW-1:0]       w_best;
  logic [LW-1:0]       w_best_lag;
  logic [16:0]         w_shift;
  logic [16:0]         w_sub;
  logic                w_lo;
  logic                w_hi;
  logic                w_fold_done;
  logic [15:0]         w_clamp;
  logic signed [16:0]  w_diff;
  logic signed [16:0]  w_step;
  assign w_wr        = flux_valid && r_state == S_IDLE;
  assign w_drop      = flux_valid && r_state != S_IDLE;
  assign w_go        = r_hop == HW'(HOP) && r_fill >= FW'(WIN + LAG_MAX);
  // x[base-j] and x[base-j-L]; pointer width wraps modulo N
  assign w_ia        = r_base - PW'(r_j);
  assign w_ib        = w_ia - PW'(r_lag);
  assign w_prod      = PRW'(r_buf[w_ia]) * PRW'(r_buf[w_ib]);
  // strict greater-than keeps the smallest lag on ties
  assign w_gt        = r_acc > r_best;
  assign w_best      = w_gt ? r_acc : r_best;
  assign w_best_lag  = w_gt ? r_lag : r_best_lag;
  // restoring divide: r_quo doubles as dividend shift register and quotient
  assign w_shift     = {r_rem, r_quo[15]};
  assign w_sub       = w_shift - 17'(r_best_lag);
  assign w_lo        = r_quo < 16'(MIN_BPM);
  assign w_hi        = r_quo > 16'(MAX_BPM);
  assign w_fold_done = (!w_lo && !w_hi) || r_steps == 4'd8;
  assign w_clamp     = w_lo ? 16'(MIN_BPM) : w_hi ? 16'(MAX_BPM) : r_quo;
  assign w_diff      = $signed({1'b0, w_clamp}) - $signed({1'b0, r_bpm});
  assign w_step      = w_diff >>> SMOOTH_SH;
  // history storage carries no reset; it is only read once fill qualifies
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wr_ptr] <= flux_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_base     <= '0;
      r_fill     <= '0;
      r_hop      <= '0;
      r_j        <= '0;
      r_lag      <= '0;
      r_best_lag <= '0;
      r_acc      <= '0;
      r_best     <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_steps    <= '0;
      r_bpm      <= '0;
      r_valid    <= 1'b0;
      r_drops    <= '0;
      r_first    <= 1'b1;
    end else begin
      r_drops <= (w_drop && r_drops != 8'hFF) ? r_drops + 8'd1 : r_drops;
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (r_fill != FW'(N)) r_fill <= r_fill + FW'(1);
          end
          r_hop <= w_go ? '0 : (w_wr && r_hop != HW'(HOP)) ? r_hop + HW'(1) : r_hop;
          if (w_go) begin
            r_state    <= S_CORR;
            // newest sample includes one written on this very edge
            r_base     <= w_wr ? r_wr_ptr : r_wr_ptr - PW'(1);
            r_j        <= '0;
            r_lag      <= LW'(LAG_MIN);
            r_acc      <= '0;
            r_best     <= '0;
            r_best_lag <= LW'(LAG_MIN);
          end
        end
        S_CORR: begin
          if (r_j != JW'(WIN)) begin
            r_acc <= r_acc + AW'(w_prod);
            r_j   <= r_j + JW'(1);
          end else begin
            r_best     <= w_best;
            r_best_lag <= w_best_lag;
            r_acc      <= '0;
            r_j        <= '0;
            r_lag      <= r_lag + LW'(1);
            if (r_lag == LW'(LAG_MAX)) begin
              r_state <= (w_best == '0) ? S_IDLE : S_DIV;
              r_quo   <= 16'(K);
              r_rem   <= '0;
              r_cnt   <= '0;
            end
          end
        end
        S_DIV: begin
          r_quo <= {r_quo[14:0], ~w_sub[16]};
          r_rem <= w_sub[16] ? w_shift[15:0] : w_sub[15:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= S_FOLD;
            r_steps <= '0;
          end
        end
        S_FOLD: begin
          if (w_fold_done) begin
            r_bpm   <= (SMOOTH_SH == 0 || r_first) ? w_clamp : r_bpm + 16'(w_step);
            r_first <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_quo   <= w_lo ? {r_quo[14:0], 1'b0} : r_quo >> 1;
            r_steps <= r_steps + 4'd1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign BPM_estimate = r_bpm;
  assign bpm_valid    = r_valid;
  assign state_out    = r_state;
  assign drop_count   = r_drops;
endmodule

// File: doc/autocorr_tempo_est.md
AUTOCORR_TEMPO_EST -- requirements
Module: autocorr_tempo_est

Interface
REQ-001 Parameter W, 16, flux sample width (unsigned).
REQ-002 Parameter N, 256, history buffer depth; power of two; N >= WIN+LAG_MAX.
REQ-003 Parameter WIN, 128, correlation window length in samples.
REQ-004 Parameter LAG_MIN, 20, smallest lag searched; >= 1.
REQ-005 Parameter LAG_MAX, 100, largest lag searched; > LAG_MIN.
REQ-006 Parameter HOP, 64, accepted samples between analysis starts.
REQ-007 Parameter FLUX_RATE_HZ, 86, flux frame rate; 60*FLUX_RATE_HZ < 2^16.
REQ-008 Parameter MIN_BPM, 60, lower bound of octave-fold range.
REQ-009 Parameter MAX_BPM, 180, upper bound; MAX_BPM >= 2*MIN_BPM.
REQ-010 Parameter SMOOTH_SH, 0, IIR smoothing shift; 0 = bypass.
REQ-011 clk  input  1  sole clock, all state on rising edge.
REQ-012 reset  input  1  asynchronous, active-low reset.
REQ-013 flux_valid  input  1  qualifies flux_in for one cycle.
REQ-014 flux_in  input  W  spectral-flux sample.
REQ-015 BPM_estimate  output  16  current tempo estimate, integer BPM.
REQ-016 bpm_valid  output  1  one-cycle pulse, new BPM_estimate.
REQ-017 state_out  output  3  FSM state: IDLE=0, CORR=1, DIV=2, FOLD=3, DONE=4.
REQ-018 drop_count  output  8  saturating count of samples dropped while busy.

Function
REQ-019 In IDLE, each flux_valid writes flux_in to the circular buffer at wr_ptr, increments wr_ptr (mod N), fill count (saturating at N) and hop count.
REQ-020 IDLE -> CORR the cycle after hop count reaches HOP with fill count >= WIN+LAG_MAX; hop count clears, base pointer latches newest sample index.
REQ-021 In CORR, for each lag L from LAG_MIN to LAG_MAX: R(L) = sum over j=0..WIN-1 of x[base-j]*x[base-j-L], one MAC per cycle, plus one compare cycle; WIN+1 cycles per lag.
REQ-022 Accumulator width 2W+clog2(WIN); no overflow or saturation possible.
REQ-023 Peak tracking uses strict greater-than; on ties the smallest lag wins.
REQ-024 If peak R == 0 after the last lag, go to IDLE; no bpm_valid, BPM_estimate holds.
REQ-025 Otherwise CORR -> DIV: restoring divide (60*FLUX_RATE_HZ)/best_lag, 16 cycles, quotient truncated.
REQ-026 DIV -> FOLD: per cycle, double if < MIN_BPM, halve if > MAX_BPM; exit when in range or after 8 steps, then clamp to [MIN_BPM, MAX_BPM].
REQ-027 FOLD -> DONE: with SMOOTH_SH=0 or first estimate since reset, BPM_estimate loads the folded value; else BPM_estimate += (folded - BPM_estimate) >>> SMOOTH_SH (signed).
REQ-028 DONE: bpm_valid high exactly one cycle; next cycle IDLE.
REQ-029 flux_valid in any state other than IDLE drops the sample (no buffer write, no hop count); drop_count increments, saturating at 255.
REQ-030 bpm_valid and BPM_estimate change only in DONE; BPM_estimate holds otherwise.

Reset
REQ-031 On reset low, immediately: state IDLE, BPM_estimate=0, bpm_valid=0, state_out=0, drop_count=0, wr_ptr/fill/hop counts=0, first-estimate flag set.
REQ-032 Reset asserted mid-analysis aborts it; no bpm_valid before a fresh fill completes.
REQ-033 Buffer contents need no reset; they are never read before fill count qualifies.

Verification
REQ-034 Defaults; impulse train flux_in=1000 every 43rd sample, else 0, 400 samples -> bpm_valid pulses, BPM_estimate=120.
REQ-035 Impulse period 86 -> BPM_estimate=60; period 25 (raw 206) -> folded to 103.
REQ-036 All-zero flux for 600 samples -> bpm_valid never asserts, BPM_estimate=0, state_out returns to 0.
REQ-037 flux_valid every cycle during CORR -> drop_count increments per sample, saturates at 255, no buffer write.
REQ-038 Reset low during CORR -> outputs 0 same cycle; after release, first bpm_valid only after 228 accepted samples and a full analysis.
REQ-039 SMOOTH_SH=2; period 43 then period 86 -> second estimate 120 + (60-120)>>>2 = 105.
